eu_loadstore_arbiter: RTL and testbench

- Shares one external memory port between the three VLIW execution units (eu0..eu2).
- Each EU presents a load or store request: address, size, sign-extend flag and write data.
- The arbiter grants one request at a time using round-robin. It drives the byte-lane bus cycle, aligns and extends read data, and returns a one-cycle completion pulse to the granted EU.
- Sits between the execution units and the vliw core's memory interface.

---
 rtl/eu_loadstore_arbiter_if.sv | 37 +++
 rtl/eu_loadstore_arbiter.sv | 166 ++++++++++++++++
 tb/tb_eu_loadstore_arbiter.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eu_loadstore_arbiter_if.sv
// Request/response and memory-bus bundle shared by the three execution units and the arbiter.
// The master modport is the arbiter's view; slave is the EU/memory side.
interface eu_loadstore_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic [2:0]          req_valid;
  logic [2:0]          req_write;
  logic [3*ADDR_W-1:0] req_addr;
  logic [5:0]          req_size;
  logic [2:0]          req_sext;
  logic [95:0]         req_wdata;
  logic [2:0]          done;
  logic [31:0]         rsp_rdata;
  logic                rsp_err;
  logic                mem_valid;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [3:0]          mem_sel;
  logic [31:0]         mem_wdata;
  logic                mem_ack;
  logic [31:0]         mem_rdata;
  logic                busy;

  modport master (
    input  req_valid, req_write, req_addr, req_size, req_sext, req_wdata,
    input  mem_ack, mem_rdata,
    output done, rsp_rdata, rsp_err,
    output mem_valid, mem_we, mem_addr, mem_sel, mem_wdata, busy
  );

  modport slave (
    output req_valid, req_write, req_addr, req_size, req_sext, req_wdata,
    output mem_ack, mem_rdata,
    input  done, rsp_rdata, rsp_err,
    input  mem_valid, mem_we, mem_addr, mem_sel, mem_wdata, busy
  );
endinterface

// File: rtl/eu_loadstore_arbiter.sv
// Round-robin load/store arbiter: three EUs share one memory port, with lane steering,
// load alignment/extension, misalignment rejection and an ISSUE timeout.
module eu_loadstore_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                   wb_clk_i,
  input logic                   rst,
  eu_loadstore_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t              state, next;
  logic [1:0]          ptr, grant, pick, cand;
  logic                found;
  logic [ADDR_W-1:0]   sel_addr, addr_q;
  logic [1:0]          sel_size, size_q;
  logic [31:0]         sel_wdata, wdata_q;
  logic                sel_write, sel_sext, write_q, sext_q;
  logic                misaligned;
  logic [7:0]          cnt;
  logic [31:0]         rdata_q, shifted, load_val;
  logic                err_q;

  // Round-robin search starting at ptr, wrapping mod 3
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      cand = 2'((32'(ptr) + k) % 3);
      if (!found && bus.req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    sel_addr  = bus.req_addr[0 +: ADDR_W];
    sel_size  = bus.req_size[1:0];
    sel_wdata = bus.req_wdata[31:0];
    sel_write = bus.req_write[0];
    sel_sext  = bus.req_sext[0];
    for (int unsigned i = 1; i < 3; i++) begin
      if (pick == 2'(i)) begin
        sel_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
        sel_size  = bus.req_size[2*i +: 2];
        sel_wdata = bus.req_wdata[32*i +: 32];
        sel_write = bus.req_write[i];
        sel_sext  = bus.req_sext[i];
      end
    end
    misaligned = ((sel_size == 2'd1) && sel_addr[0]) ||
                 (sel_size[1] && (sel_addr[1:0] != 2'b00));
  end

  always_comb begin
    shifted  = bus.mem_rdata >> {addr_q[1:0], 3'b000};
    load_val = shifted;
    case (size_q)
      2'd0:    load_val = {{24{sext_q & shifted[7]}},  shifted[7:0]};
      2'd1:    load_val = {{16{sext_q & shifted[15]}}, shifted[15:0]};
      default: load_val = shifted;
    endcase
    if (write_q) load_val = '0;
  end

  always_ff @(posedge wb_clk_i or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  // Ack takes priority over a timeout landing in the same cycle
  always_comb begin
    next = state;
    case (state)
      IDLE:    if (found) next = misaligned ? DONE : ISSUE;
      ISSUE:   if (bus.mem_ack || (cnt == TO_LAST)) next = DONE;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge rst) begin
    if (rst) begin
      ptr     <= '0;
      grant   <= '0;
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      sext_q  <= 1'b0;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (found) begin
          grant   <= pick;
          addr_q  <= sel_addr;
          size_q  <= sel_size;
          wdata_q <= sel_wdata;
          write_q <= sel_write;
          sext_q  <= sel_sext;
          cnt     <= '0;
          rdata_q <= '0;
          err_q   <= misaligned;
        end
        ISSUE: begin
          if (bus.mem_ack) begin
            rdata_q <= load_val;
            err_q   <= 1'b0;
          end else if (cnt == TO_LAST) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          ptr <= (grant == 2'd2) ? 2'd0 : grant + 2'd1;
          cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.busy      = (state != IDLE);
    bus.mem_valid = (state == ISSUE);
    bus.mem_we    = (state == ISSUE) && write_q;
    bus.mem_addr  = '0;
    bus.mem_sel   = '0;
    bus.mem_wdata = '0;
    bus.done      = '0;
    bus.rsp_rdata = '0;
    bus.rsp_err   = 1'b0;
    if (state == ISSUE) begin
      bus.mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
      case (size_q)
        2'd0: begin
          bus.mem_sel   = 4'b0001 << addr_q[1:0];
          bus.mem_wdata = {4{wdata_q[7:0]}};
        end
        2'd1: begin
          bus.mem_sel   = addr_q[1] ? 4'b1100 : 4'b0011;
          bus.mem_wdata = {2{wdata_q[15:0]}};
        end
        default: begin
          bus.mem_sel   = 4'b1111;
          bus.mem_wdata = wdata_q;
        end
      endcase
      if (!write_q) bus.mem_wdata = '0;
    end
    if (state == DONE) begin
      bus.done      = 3'b001 << grant;
      bus.rsp_rdata = rdata_q;
      bus.rsp_err   = err_q;
    end
  end
endmodule

// File: tb/tb_eu_loadstore_arbiter.sv
// Randomized self-checking bench for eu_loadstore_arbiter against a behavioural model
// of lane mapping, load extension, timeout and round-robin grant order.
module tb_eu_loadstore_arbiter;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   model_ptr = 0;

  always #5 clk = ~clk;

  eu_loadstore_arbiter_if #(.ADDR_W(32)) bus ();

  eu_loadstore_arbiter #(.ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .wb_clk_i (clk),
    .rst      (rst),
    .bus      (bus)
  );

  function automatic logic [31:0] load_value(logic [31:0] d, logic [31:0] a, int size, bit sext);
    logic [31:0] s;
    s = d >> (8 * (a % 4));
    if (size == 0) begin
      s = s % 256;
      if (sext && s >= 128) s = s + 32'hFFFF_FF00;
    end else if (size == 1) begin
      s = s % 65536;
      if (sext && s >= 32768) s = s + 32'hFFFF_0000;
    end
    return s;
  endfunction

  function automatic logic [3:0] lane_sel(logic [31:0] a, int size);
    if (size == 0) return 4'(1 << (a % 4));
    if (size == 1) return (a % 4 >= 2) ? 4'd12 : 4'd3;
    return 4'd15;
  endfunction

  function automatic logic [31:0] lane_data(logic [31:0] w, int size);
    if (size == 0) return (w % 256) * 32'h0101_0101;
    if (size == 1) return (w % 65536) * 32'h0001_0001;
    return w;
  endfunction

  function automatic int rr_pick(logic [2:0] mask);
    int idx;
    for (int k = 0; k < 3; k++) begin
      idx = (model_ptr + k) % 3;
      if (mask[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic clear_inputs();
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_size  = '0;
    bus.req_sext  = '0;
    bus.req_wdata = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
  endtask

  // One EU transaction; ack_on = ISSUE cycle carrying the ack (0 = never)
  task automatic do_txn(input int eu, input bit wr, input logic [31:0] addr, input int size,
                        input bit sext, input logic [31:0] wdata, input int ack_on,
                        input logic [31:0] rdata, input string name);
    bit mis, exp_err, seen;
    int exp_issue, c, issue_n;
    logic [31:0] exp_rd, exp_wd;
    logic [3:0]  exp_sel;
    mis = (size == 1 && addr % 2 != 0) || (size >= 2 && addr % 4 != 0);
    if (mis) begin exp_issue = 0; exp_err = 1; end
    else if (ack_on >= 1 && ack_on <= TO) begin exp_issue = ack_on; exp_err = 0; end
    else begin exp_issue = TO; exp_err = 1; end
    exp_rd  = (exp_err || wr) ? 32'd0 : load_value(rdata, addr, size, sext);
    exp_sel = lane_sel(addr, size);
    exp_wd  = wr ? lane_data(wdata, size) : 32'd0;

    @(negedge clk);
    bus.req_valid = 3'(1 << eu);
    bus.req_write[eu] = wr;
    bus.req_addr[eu*32 +: 32] = addr;
    bus.req_size[eu*2 +: 2] = 2'(size);
    bus.req_sext[eu] = sext;
    bus.req_wdata[eu*32 +: 32] = wdata;
    bus.mem_ack = 1'($urandom_range(0, 1));
    c = 0; issue_n = 0; seen = 0;
    while (!seen && c < 40) begin
      @(negedge clk);
      c++;
      if (bus.mem_valid) begin
        issue_n++;
        checks++;
        if (bus.mem_addr !== (addr & ~32'd3) || bus.mem_sel !== exp_sel ||
            bus.mem_we !== wr || bus.mem_wdata !== exp_wd || bus.busy !== 1'b1) begin
          failures++;
          $display("FAIL %s bus: addr=%h sel=%b we=%b wdata=%h busy=%b required addr=%h sel=%b we=%b wdata=%h busy=1",
                   name, bus.mem_addr, bus.mem_sel, bus.mem_we, bus.mem_wdata, bus.busy,
                   addr & ~32'd3, exp_sel, wr, exp_wd);
        end
        if (issue_n == 1) begin
          bus.req_addr[eu*32 +: 32]  = $urandom;
          bus.req_wdata[eu*32 +: 32] = $urandom;
          bus.req_size[eu*2 +: 2]    = 2'($urandom_range(0, 3));
          bus.req_sext[eu]           = ~sext;
          bus.req_write[eu]          = ~wr;
          if ($urandom_range(0, 3) == 0) bus.req_valid = '0;
        end
        bus.mem_ack   = (issue_n == ack_on);
        bus.mem_rdata = (issue_n == ack_on) ? rdata : $urandom;
      end else if (bus.done !== 3'b000) begin
        seen = 1;
        checks++;
        if (bus.done !== 3'(1 << eu) || bus.rsp_rdata !== exp_rd || bus.rsp_err !== exp_err ||
            issue_n != exp_issue || c != exp_issue + 1) begin
          failures++;
          $display("FAIL %s done: done=%b rdata=%h err=%b issue=%0d lat=%0d required done=%b rdata=%h err=%b issue=%0d lat=%0d",
                   name, bus.done, bus.rsp_rdata, bus.rsp_err, issue_n, c,
                   3'(1 << eu), exp_rd, exp_err, exp_issue, exp_issue + 1);
        end
        model_ptr = (eu + 1) % 3;
        bus.req_valid = '0;
        bus.mem_ack = 1'($urandom_range(0, 1));
      end else begin
        bus.mem_ack = 1'($urandom_range(0, 1));
      end
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL %s no done within %0d cycles, required done=%b", name, c, 3'(1 << eu));
      bus.req_valid = '0;
    end
    @(negedge clk);
    bus.mem_ack = 1'b0;
    checks++;
    if (bus.done !== 3'b000 || bus.rsp_rdata !== 32'd0 || bus.rsp_err !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL %s after: done=%b rdata=%h err=%b busy=%b required all 0",
               name, bus.done, bus.rsp_rdata, bus.rsp_err, bus.busy);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.done !== 0 || bus.rsp_rdata !== 0 || bus.rsp_err !== 0 || bus.mem_valid !== 0 ||
        bus.mem_we !== 0 || bus.mem_addr !== 0 || bus.mem_sel !== 0 || bus.mem_wdata !== 0 || bus.busy !== 0) begin
      failures++;
      $display("FAIL reset: done=%b rdata=%h err=%b valid=%b we=%b addr=%h sel=%b wdata=%h busy=%b required all 0",
               bus.done, bus.rsp_rdata, bus.rsp_err, bus.mem_valid, bus.mem_we, bus.mem_addr,
               bus.mem_sel, bus.mem_wdata, bus.busy);
    end
    rst = 1'b0;
    model_ptr = 0;
  endtask

  task automatic test_single_load();
    do_txn(1, 1'b0, 32'h1003, 0, 1'b1, 32'h0, 2, 32'h80AA_BBCC, "single_load");
  endtask

  task automatic test_store_lanes();
    do_txn(0, 1'b1, 32'h2002, 1, 1'b0, 32'h1234, 1, 32'hDEAD_BEEF, "store_half");
    do_txn(2, 1'b1, 32'h3001, 0, 1'b0, 32'hA5, 1, 32'h0, "store_byte");
    do_txn(1, 1'b1, 32'h3008, 2, 1'b0, 32'hCAFE_F00D, 3, 32'h0, "store_word");
    do_txn(0, 1'b0, 32'h4002, 1, 1'b1, 32'h0, 1, 32'h8001_7FFF, "load_half_sext");
    do_txn(2, 1'b0, 32'h4001, 0, 1'b0, 32'h0, 1, 32'h0000_9900, "load_byte_zext");
  endtask

  task automatic test_misaligned();
    do_txn(2, 1'b0, 32'h0006, 2, 1'b0, 32'h0, 1, 32'h1234_5678, "misaligned_word");
    do_txn(0, 1'b1, 32'h0011, 1, 1'b0, 32'hFFFF, 1, 32'h0, "misaligned_half");
  endtask

  task automatic test_timeout();
    do_txn(1, 1'b0, 32'h5000, 2, 1'b0, 32'h0, 0, 32'h1111_2222, "timeout");
    do_txn(0, 1'b0, 32'h5004, 2, 1'b0, 32'h0, TO, 32'h3333_4444, "ack_at_limit");
    do_txn(2, 1'b1, 32'h5008, 2, 1'b0, 32'h5555, TO + 1, 32'h0, "ack_too_late");
  endtask

  task automatic test_reset_mid();
    int c;
    @(negedge clk);
    bus.req_valid = 3'b100;
    bus.req_write = '0;
    bus.req_addr[64 +: 32] = 32'h40;
    bus.req_size[5:4] = 2'd2;
    bus.mem_ack = 1'b0;
    c = 0;
    while (!bus.mem_valid && c < 5) begin
      @(negedge clk);
      c++;
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.mem_valid !== 1'b0 || bus.busy !== 1'b0 || c == 5) begin
      failures++;
      $display("FAIL reset_mid: mem_valid=%b busy=%b waited=%0d required mem_valid=0 busy=0 in ISSUE",
               bus.mem_valid, bus.busy, c);
    end
    bus.req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    model_ptr = 0;
  endtask

  task automatic test_round_robin(input logic [2:0] mask, input int grants);
    logic [31:0] addrs [3];
    logic [31:0] saved;
    int n, c, last, exp_eu;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      addrs[i] = $urandom & ~32'd3;
      bus.req_addr[i*32 +: 32] = addrs[i];
      bus.req_size[i*2 +: 2] = 2'd2;
    end
    bus.req_write = '0;
    bus.req_sext  = '0;
    bus.req_valid = mask;
    bus.mem_ack   = 1'b0;
    saved = '0; n = 0; c = 0; last = -1;
    while (n < grants && c < 80) begin
      @(negedge clk);
      c++;
      if (bus.mem_valid) begin
        exp_eu = rr_pick(mask);
        checks++;
        if (bus.mem_addr !== addrs[exp_eu]) begin
          failures++;
          $display("FAIL rr_addr: mem_addr=%h required %h (eu%0d)", bus.mem_addr, addrs[exp_eu], exp_eu);
        end
        bus.mem_ack = 1'b1;
        bus.mem_rdata = $urandom;
        saved = bus.mem_rdata;
      end else begin
        bus.mem_ack = 1'b0;
        if (bus.done !== 3'b000) begin
          exp_eu = rr_pick(mask);
          checks++;
          if (bus.done !== 3'(1 << exp_eu) || bus.rsp_rdata !== saved || bus.rsp_err !== 1'b0 ||
              (last >= 0 && c - last != 3)) begin
            failures++;
            $display("FAIL rr_done: done=%b rdata=%h err=%b gap=%0d required done=%b rdata=%h err=0 gap=3",
                     bus.done, bus.rsp_rdata, bus.rsp_err, c - last, 3'(1 << exp_eu), saved);
          end
          last = c;
          model_ptr = (exp_eu + 1) % 3;
          n++;
          if (n == grants) bus.req_valid = '0;
        end
      end
    end
    if (n < grants) begin
      checks++; failures++;
      bus.req_valid = '0;
      $display("FAIL rr_timeout: grants=%0d required %0d", n, grants);
    end
    @(negedge clk);
  endtask

  task automatic test_random(input int iters);
    int eu, size, ack_on;
    bit wr, sext;
    logic [31:0] addr;
    for (int i = 0; i < iters; i++) begin
      eu     = $urandom_range(0, 2);
      wr     = 1'($urandom_range(0, 1));
      size   = $urandom_range(0, 3);
      sext   = 1'($urandom_range(0, 1));
      addr   = $urandom;
      if ($urandom_range(0, 2) != 0) addr = addr & ~32'd3;
      ack_on = $urandom_range(0, TO + 1);
      do_txn(eu, wr, addr, size, sext, $urandom, ack_on, $urandom, "random");
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_load();
    test_store_lanes();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    test_round_robin(3'b111, 6);
    test_round_robin(3'b101, 4);
    test_round_robin(3'b110, 3);
    test_random(40);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
